matrix_key_scan: RTL and testbench
==================================

// Module: matrix_key_scan
// PURPOSE
//   Input-side counterpart of the 8-digit 7-segment scan path: scans a 4x4 matrix keypad.
//   - Drives one column low at a time and samples the rows.
//   - Debounces press and release.
//   - Emits a 4-bit key code, a one-cycle valid strobe and a held-down level.
//   - The key code feeds digit data nibbles (d0/d1) of the display top level.
// PARAMETERS
//   CLK_HZ     50_000_000  input clock frequency, Hz
//   SCAN_HZ    1_000       column scan tick rate, Hz (tick period = CLK_HZ/SCAN_HZ cycles)
//   DEB_TICKS  20          consecutive stable scan ticks needed to accept a press or a release
// PORTS
//   clk_50mhz  in   1  system clock
//   rst        in   1  asynchronous reset, active-low
//   row        in   4  keypad rows, active-low, pulled up externally, asynchronous to clk
//   col        out  4  keypad column drive, active-low, exactly one bit low at all times
//   key_code   out  4  last accepted key = {row_idx[1:0], col_idx[1:0]}
//   key_valid  out  1  one-cycle pulse when a debounced press is accepted
//   key_down   out  1  high from accept until the debounced release completes
// BEHAVIOUR
//   - Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, FSM=SCAN, counters=0.
//   - row passes through a 2-flop synchronizer; all decisions use the synchronized value (rs).
//   - tick: one-cycle pulse every CLK_HZ/SCAN_HZ cycles; counter wraps to 0 after the pulse.
//   - Every FSM action below happens only on a tick cycle. The FSM holds state between ticks.
//   - SCAN:
//     - rs==4'hF: rotate col 1110->1101->1011->0111->1110.
//     - otherwise: latch col_idx and row_idx, deb_cnt=1, go to DEBOUNCE; col is held.
//     - row_idx = lowest-index row bit that is 0 (multi-key: lowest row wins).
//   - DEBOUNCE:
//     - rs still has bit row_idx low: deb_cnt++.
//       When deb_cnt reaches DEB_TICKS: key_code={row_idx,col_idx}, key_valid=1 for exactly
//       one clk (the cycle after that tick), key_down=1, go to PRESSED.
//     - otherwise (bounce or release): deb_cnt=0, go to SCAN, resume rotation from the held column.
//   - PRESSED:
//     - rs==4'hF: deb_cnt=1, go to RELEASE.
//     - otherwise stay; col stays held.
//     - Additional keys pressed in this state are ignored (no rollover).
//   - RELEASE:
//     - rs==4'hF: deb_cnt++. When deb_cnt reaches DEB_TICKS: key_down=0, go to SCAN.
//     - any row low: back to PRESSED, deb_cnt=0.
//   - key_code holds its value until the next accepted press. It does not clear on release.
//   - Latency: from a stable press aligned to the scanned column, key_valid rises
//     DEB_TICKS-1 ticks after the detecting tick, plus 1 clk for the registered output.
//   - Reset asserted mid-operation returns everything to reset values immediately
//     (asynchronous). No key_valid is emitted on reset release.
//   - key_valid never pulses twice for one physical press, however long the key is held.
//   - Width rules: the prescaler counter is $clog2(CLK_HZ/SCAN_HZ) bits; deb_cnt is
//     $clog2(DEB_TICKS+1) bits and saturates, it never wraps.
// STRUCTURE
//   - Shared package key_pkg:
//     - state encoding: SCAN=2'd0, DEBOUNCE=2'd1, PRESSED=2'd2, RELEASE=2'd3
//     - KEY_W=4
//     - COL_IDLE=4'b1110
//   - Sub-module tick_gen (CLK_HZ, TICK_HZ):
//     - prescaler producing the one-cycle tick
//     - reusable by the display scan divider
//   - Everything else (synchronizer, FSM, col shifter, code register) lives in this module.
// TESTING  (CLK_HZ=1000, SCAN_HZ=100 -> tick every 10 clk; DEB_TICKS=3)
//   1. Reset, rows idle 4'hF for 80 clk
//      -> col sequence 1110,1101,1011,0111,1110 changing every 10 clk;
//         key_valid stays 0; key_code=0.
//   2. Hold row=4'b1011 while col=1101 (row2, col1), keep it for 100 clk
//      -> exactly one key_valid pulse, key_code=4'h9, key_down=1; col frozen at 1101.
//   3. Release after test 2
//      -> key_down falls 3 ticks after rows read 4'hF; scanning resumes; key_code stays 4'h9.
//   4. Bounce: row low for 1 tick, high 1 tick, then stable low on col=0111 row0
//      -> no pulse on the bounce; single key_valid later with key_code=4'h3.
//   5. Rows 4'b0101 (row1 and row3 low) on col=1110
//      -> key_code=4'h4 (row1, lowest index wins), one pulse.
//   6. Assert rst during PRESSED, then release and keep the key held
//      -> outputs at reset values immediately, col=1110;
//         a fresh debounce then gives one new key_valid pulse.

Source files
------------

// File: rtl/key_pkg.sv
// ============================================================================
// key_pkg : shared types and constants for the matrix keypad scanner
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package key_pkg;

    localparam int         KEY_W    = 4;
    localparam logic [3:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Index of the lowest active-low bit; when several are low the lowest index wins.
    function automatic logic [1:0] low_zero_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : prescaler emitting a one-cycle tick every CLK_HZ/TICK_HZ clocks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_key_scan.sv
// ============================================================================
// matrix_key_scan : 4x4 keypad column scanner with press/release debounce
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module matrix_key_scan
    import key_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int DEB_TICKS = 20
) (
    input  logic             clk_50mhz,
    input  logic             rst,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam int            DW      = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_TICKS);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);

    logic             tick;
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    state_t           state_q;
    logic [3:0]       col_q;
    logic [1:0]       col_idx_q;
    logic [1:0]       row_idx_q;
    logic [DW-1:0]    deb_q;
    logic [DW-1:0]    deb_d;
    logic [KEY_W-1:0] key_code_q;
    logic             key_valid_q;
    logic             key_down_q;
    logic             rows_idle;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (SCAN_HZ)
    ) u_tick_gen (
        .clk_i  (clk_50mhz),
        .rst_ni (rst),
        .tick_o (tick)
    );

    // Rows idle high, so the synchronizer resets to "no key" to avoid a phantom press.
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    assign rows_idle = (row_sync_q == 4'hF);
    assign deb_d     = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            col_q       <= COL_IDLE;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (rows_idle) begin
                            col_q <= {col_q[2:0], col_q[3]};
                        end else begin
                            col_idx_q <= low_zero_idx(col_q);
                            row_idx_q <= low_zero_idx(row_sync_q);
                            deb_q     <= DEB_ONE;
                            state_q   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!row_sync_q[row_idx_q]) begin
                            deb_q <= deb_d;
                            if (deb_d == DEB_MAX) begin
                                key_code_q  <= {row_idx_q, col_idx_q};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                                state_q     <= PRESSED;
                            end
                        end else begin
                            // Column is still held, so rotation resumes from where it stopped.
                            deb_q   <= '0;
                            state_q <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (rows_idle) begin
                            deb_q   <= DEB_ONE;
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (rows_idle) begin
                            deb_q <= deb_d;
                            if (deb_d == DEB_MAX) begin
                                deb_q      <= '0;
                                key_down_q <= 1'b0;
                                state_q    <= SCAN;
                            end
                        end else begin
                            deb_q   <= '0;
                            state_q <= PRESSED;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_key_scan.sv
// ============================================================================
// tb_matrix_key_scan : directed self-checking bench for matrix_key_scan
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_matrix_key_scan;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    matrix_key_scan #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .DEB_TICKS (3)
    ) dut (
        .clk_50mhz (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) npulse++;
    end

    // Returns at the first falling edge where col shows the wanted value.
    task automatic wait_col(input logic [3:0] c, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (col === c) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        row = 4'hF;
        repeat (3) @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_down got %b want 0", key_down); end
        rst = 1'b1;
    endtask

    task automatic test_idle_scan;
        logic [3:0] seq [0:4];
        int p0;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;
        p0 = npulse;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k % 10 == 5 && k < 50) begin
                checks++;
                if (col !== seq[k/10]) begin
                    errors++; $display("FAIL idle_col@%0d got %b want %b", k, col, seq[k/10]);
                end
            end
        end
        checks++; if (npulse != p0) begin errors++; $display("FAIL idle_pulses got %0d want 0", npulse - p0); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL idle_code got %h want 0", key_code); end
    endtask

    task automatic test_press;
        bit ok;
        int p0, first;
        wait_col(4'b1101, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press_wait_col timeout col %b want 1101", col); end
        row = 4'b1011;
        p0 = npulse; first = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && first < 0) first = i;
        end
        checks++; if (first != 30) begin errors++; $display("FAIL press_latency got %0d want 30", first); end
        checks++; if (npulse - p0 != 1) begin errors++; $display("FAIL press_pulses got %0d want 1", npulse - p0); end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL press_code got %h want 9", key_code); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL press_down got %b want 1", key_down); end
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL press_col got %b want 1101", col); end
    endtask

    task automatic test_release;
        int fall, p0;
        row = 4'hF;
        fall = -1; p0 = npulse;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            if (key_down === 1'b0 && fall < 0) fall = j;
        end
        checks++; if (fall != 30) begin errors++; $display("FAIL release_fall got %0d want 30", fall); end
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL release_col got %b want 1011", col); end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL release_code got %h want 9", key_code); end
        checks++; if (npulse != p0) begin errors++; $display("FAIL release_pulses got %0d want 0", npulse - p0); end
    endtask

    task automatic test_bounce;
        bit ok;
        int p0, first, fall;
        wait_col(4'b0111, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_wait_col timeout col %b want 0111", col); end
        row = 4'b1110;
        p0 = npulse; first = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && first < 0) first = i;
            if (i == 10) row = 4'hF;
            if (i == 20) row = 4'b1110;
        end
        checks++; if (first != 50) begin errors++; $display("FAIL bounce_latency got %0d want 50", first); end
        checks++; if (npulse - p0 != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", npulse - p0); end
        checks++; if (key_code !== 4'h3) begin errors++; $display("FAIL bounce_code got %h want 3", key_code); end
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL bounce_col got %b want 0111", col); end
        row = 4'hF;
        fall = -1;
        for (int j = 1; j <= 60 && fall < 0; j++) begin
            @(negedge clk);
            if (key_down === 1'b0) fall = j;
        end
        checks++; if (fall < 0) begin errors++; $display("FAIL bounce_release timeout key_down %b want 0", key_down); end
    endtask

    task automatic test_multi_key;
        bit ok;
        int p0, first;
        wait_col(4'b1110, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_wait_col timeout col %b want 1110", col); end
        row = 4'b0101;
        p0 = npulse; first = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && first < 0) first = i;
        end
        checks++; if (first != 30) begin errors++; $display("FAIL multi_latency got %0d want 30", first); end
        checks++; if (npulse - p0 != 1) begin errors++; $display("FAIL multi_pulses got %0d want 1", npulse - p0); end
        checks++; if (key_code !== 4'h4) begin errors++; $display("FAIL multi_code got %h want 4", key_code); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL multi_down got %b want 1", key_down); end
    endtask

    task automatic test_reset_mid_press;
        int p0, first;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL midrst_col got %b want 1110", col); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midrst_code got %h want 0", key_code); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL midrst_down got %b want 0", key_down); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", key_valid); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        p0 = npulse; first = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1 && first < 0) first = i;
        end
        checks++; if (first != 30) begin errors++; $display("FAIL midrst_latency got %0d want 30", first); end
        checks++; if (npulse - p0 != 1) begin errors++; $display("FAIL midrst_pulses got %0d want 1", npulse - p0); end
        checks++; if (key_code !== 4'h4) begin errors++; $display("FAIL midrst_code_after got %h want 4", key_code); end
        row = 4'hF;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        row = 4'hF;
        test_reset;
        test_idle_scan;
        test_press;
        test_release;
        test_bounce;
        test_multi_key;
        test_reset_mid_press;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
